// File: rtl/fpu_norm_arb_if.sv
// Shared FPU01 operand widths plus the requester/result handshake bundle for fpu_norm_arb.
// The DUT takes the slave modport; request sources and the result consumer sit on the master side.
package fpu01_pkg;
   localparam int unsigned C_FPU01_MANT         = 23;
   localparam int unsigned C_FPU01_EXP          = 8;
   localparam int unsigned C_FPU01_MANT_PRENORM = 27;
   localparam int unsigned C_FPU01_EXP_PRENORM  = 10;
   localparam int unsigned C_FPU01_RM           = 3;
   localparam int unsigned C_FPU01_CMD          = 4;

   // Operand bundle carried by the issue stage into the normalizer
   typedef struct packed {
      logic [C_FPU01_MANT_PRENORM-1:0] mant;
      logic [C_FPU01_EXP_PRENORM-1:0]  exp;
      logic                            sign;
      logic [C_FPU01_RM-1:0]           rm;
      logic [C_FPU01_CMD-1:0]          op;
   } fpu01_prenorm_t;
endpackage

interface fpu_norm_arb_if #(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned TAG_WIDTH = 4,
   parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]                                    Valid_SI;
   logic [NUM_REQ-1:0]                                    Ready_SO;
   logic [NUM_REQ-1:0][fpu01_pkg::C_FPU01_MANT_PRENORM-1:0] Mant_DI;
   logic [NUM_REQ-1:0][fpu01_pkg::C_FPU01_EXP_PRENORM-1:0]  Exp_DI;
   logic [NUM_REQ-1:0]                                    Sign_DI;
   logic [NUM_REQ-1:0][fpu01_pkg::C_FPU01_RM-1:0]         RM_DI;
   logic [NUM_REQ-1:0][fpu01_pkg::C_FPU01_CMD-1:0]        OP_DI;
   logic [NUM_REQ-1:0][TAG_WIDTH-1:0]                     Tag_DI;

   logic                                  Res_Valid_SO;
   logic                                  Res_Ready_SI;
   logic [fpu01_pkg::C_FPU01_MANT:0]      Res_Mant_DO;
   logic [fpu01_pkg::C_FPU01_EXP-1:0]     Res_Exp_DO;
   logic                                  Res_Sign_SO;
   logic                                  Res_Rounded_SO;
   logic                                  Res_OF_SO;
   logic                                  Res_UF_SO;
   logic [ID_WIDTH-1:0]                   Res_Id_DO;
   logic [TAG_WIDTH-1:0]                  Res_Tag_DO;

   modport slave (
      input  Valid_SI, Mant_DI, Exp_DI, Sign_DI, RM_DI, OP_DI, Tag_DI, Res_Ready_SI,
      output Ready_SO, Res_Valid_SO, Res_Mant_DO, Res_Exp_DO, Res_Sign_SO,
             Res_Rounded_SO, Res_OF_SO, Res_UF_SO, Res_Id_DO, Res_Tag_DO
   );

   modport master (
      output Valid_SI, Mant_DI, Exp_DI, Sign_DI, RM_DI, OP_DI, Tag_DI, Res_Ready_SI,
      input  Ready_SO, Res_Valid_SO, Res_Mant_DO, Res_Exp_DO, Res_Sign_SO,
             Res_Rounded_SO, Res_OF_SO, Res_UF_SO, Res_Id_DO, Res_Tag_DO
   );
endinterface

// File: rtl/fpu_norm_arb.sv
// Round-robin sharing of one combinational normalizer: issue stage S1 -> normalizer -> result stage S2.
// Define FPU_NORM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rotation pointer).
module fpu_norm_arb #(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned TAG_WIDTH = 4,
   parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                                      Clk_CI,
   input  logic                                      Rst_RBI,
   fpu_norm_arb_if.slave                             bus,
   output logic [fpu01_pkg::C_FPU01_MANT_PRENORM-1:0] Norm_Mant_DO,
   output logic [fpu01_pkg::C_FPU01_EXP_PRENORM-1:0]  Norm_Exp_DO,
   output logic                                      Norm_Sign_SO,
   output logic [fpu01_pkg::C_FPU01_RM-1:0]          Norm_RM_SO,
   output logic [fpu01_pkg::C_FPU01_CMD-1:0]         Norm_OP_SO,
   input  logic [fpu01_pkg::C_FPU01_MANT:0]          Norm_Mant_DI,
   input  logic [fpu01_pkg::C_FPU01_EXP-1:0]         Norm_Exp_DI,
   input  logic                                      Norm_Rounded_SI,
   input  logic                                      Norm_OF_SI,
   input  logic                                      Norm_UF_SI,
   output logic                                      Busy_SO
);
   import fpu01_pkg::*;

   logic                     s1_valid;
   fpu01_prenorm_t           s1_q;
   logic [ID_WIDTH-1:0]      s1_id;
   logic [TAG_WIDTH-1:0]     s1_tag;

   logic                     s2_valid;
   logic [C_FPU01_MANT:0]    s2_mant;
   logic [C_FPU01_EXP-1:0]   s2_exp;
   logic                     s2_sign;
   logic                     s2_rnd;
   logic                     s2_of;
   logic                     s2_uf;
   logic [ID_WIDTH-1:0]      s2_id;
   logic [TAG_WIDTH-1:0]     s2_tag;

   logic                     s2_en_c;
   logic                     s1_en_c;
   logic                     found_c;
   logic                     accept_c;
   logic [ID_WIDTH-1:0]      grant_id_c;
   logic [NUM_REQ-1:0]       grant_c;
   int unsigned              idx_c;
   fpu01_prenorm_t           req_c;

`ifndef FPU_NORM_ARB_FIXED_PRIO_EN
   logic [ID_WIDTH-1:0]      ptr_q;
`endif

   assign s2_en_c  = ~s2_valid | bus.Res_Ready_SI;
   assign s1_en_c  = ~s1_valid | s2_en_c;
   assign accept_c = found_c & s1_en_c & Rst_RBI;

   // First asserted Valid_SI at or after the search start, wrapping modulo NUM_REQ
   always_comb begin
      grant_c    = '0;
      grant_id_c = '0;
      found_c    = 1'b0;
      idx_c      = 0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
`ifdef FPU_NORM_ARB_FIXED_PRIO_EN
         idx_c = off;
`else
         idx_c = 32'(ptr_q) + off;
`endif
         if (idx_c >= NUM_REQ) idx_c = idx_c - NUM_REQ;
         if (!found_c && bus.Valid_SI[ID_WIDTH'(idx_c)]) begin
            found_c    = 1'b1;
            grant_id_c = ID_WIDTH'(idx_c);
         end
      end
      if (found_c) grant_c[grant_id_c] = 1'b1;
   end

   always_comb begin
      req_c.mant = bus.Mant_DI[grant_id_c];
      req_c.exp  = bus.Exp_DI[grant_id_c];
      req_c.sign = bus.Sign_DI[grant_id_c];
      req_c.rm   = bus.RM_DI[grant_id_c];
      req_c.op   = bus.OP_DI[grant_id_c];
   end

   assign bus.Ready_SO     = Rst_RBI ? (grant_c & {NUM_REQ{s1_en_c}}) : '0;
   assign bus.Res_Valid_SO = s2_valid & Rst_RBI;
   assign Busy_SO          = (s1_valid | s2_valid) & Rst_RBI;

   assign Norm_Mant_DO = s1_q.mant;
   assign Norm_Exp_DO  = s1_q.exp;
   assign Norm_Sign_SO = s1_q.sign;
   assign Norm_RM_SO   = s1_q.rm;
   assign Norm_OP_SO   = s1_q.op;

   assign bus.Res_Mant_DO    = s2_mant;
   assign bus.Res_Exp_DO     = s2_exp;
   assign bus.Res_Sign_SO    = s2_sign;
   assign bus.Res_Rounded_SO = s2_rnd;
   assign bus.Res_OF_SO      = s2_of;
   assign bus.Res_UF_SO      = s2_uf;
   assign bus.Res_Id_DO      = s2_id;
   assign bus.Res_Tag_DO     = s2_tag;

   // Pipeline registers; payloads only move with a valid entry so idle stages keep their last value
   always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
         s1_id    <= '0;
         s1_tag   <= '0;
         s2_valid <= 1'b0;
         s2_mant  <= '0;
         s2_exp   <= '0;
         s2_sign  <= 1'b0;
         s2_rnd   <= 1'b0;
         s2_of    <= 1'b0;
         s2_uf    <= 1'b0;
         s2_id    <= '0;
         s2_tag   <= '0;
      end else begin
         if (s2_en_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_mant <= Norm_Mant_DI;
               s2_exp  <= Norm_Exp_DI;
               s2_sign <= s1_q.sign;
               s2_rnd  <= Norm_Rounded_SI;
               s2_of   <= Norm_OF_SI;
               s2_uf   <= Norm_UF_SI;
               s2_id   <= s1_id;
               s2_tag  <= s1_tag;
            end
         end
         if (s1_en_c) begin
            s1_valid <= found_c;
            if (found_c) begin
               s1_q   <= req_c;
               s1_id  <= grant_id_c;
               s1_tag <= bus.Tag_DI[grant_id_c];
            end
         end
      end
   end

`ifndef FPU_NORM_ARB_FIXED_PRIO_EN
   // Rotate past the winner only when its request is actually taken
   always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
         ptr_q <= '0;
      end else if (accept_c) begin
         if (32'(grant_id_c) + 1 >= NUM_REQ) ptr_q <= '0;
         else                                ptr_q <= grant_id_c + ID_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fpu_norm_arb.sv
// Directed self-checking bench for fpu_norm_arb with a simple normalizer stand-in.
// Honors FPU_NORM_ARB_FIXED_PRIO_EN for grant expectations.
module tb_fpu_norm_arb;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [26:0] norm_mant_o;
   logic [9:0]  norm_exp_o;
   logic        norm_sign_o;
   logic [2:0]  norm_rm_o;
   logic [3:0]  norm_op_o;
   logic [23:0] norm_mant_i;
   logic [7:0]  norm_exp_i;
   logic        norm_rnd_i, norm_of_i, norm_uf_i;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   fpu_norm_arb_if #(.NUM_REQ(2), .TAG_WIDTH(4), .ID_WIDTH(1)) bus ();

   fpu_norm_arb #(.NUM_REQ(2), .TAG_WIDTH(4), .ID_WIDTH(1)) dut (
      .Clk_CI(clk), .Rst_RBI(rst_n), .bus(bus.slave),
      .Norm_Mant_DO(norm_mant_o), .Norm_Exp_DO(norm_exp_o), .Norm_Sign_SO(norm_sign_o),
      .Norm_RM_SO(norm_rm_o), .Norm_OP_SO(norm_op_o),
      .Norm_Mant_DI(norm_mant_i), .Norm_Exp_DI(norm_exp_i),
      .Norm_Rounded_SI(norm_rnd_i), .Norm_OF_SI(norm_of_i), .Norm_UF_SI(norm_uf_i),
      .Busy_SO(busy)
   );

   // Normalizer stand-in: drop guard bits, truncate exponent, derive flags
   always_comb begin
      norm_mant_i = norm_mant_o[26:3];
      norm_exp_i  = norm_exp_o[7:0];
      norm_rnd_i  = |norm_mant_o[2:0];
      norm_of_i   = ~norm_exp_o[9] & norm_exp_o[8];
      norm_uf_i   = norm_exp_o[9];
   end

   function automatic logic [26:0] f_mant(input int id, input int tag);
      logic [3:0] t;
      t = 4'(tag);
      return {3'(id), t, 17'h1B2C3, t[0], 2'b00};
   endfunction
   function automatic logic [9:0] f_exp(input int id, input int tag);
      logic [3:0] t;
      t = 4'(tag);
      return {t[1], t[2], t, 4'(id)};
   endfunction
   function automatic logic f_sign(input int id, input int tag);
      logic [3:0] t;
      t = 4'(tag);
      return t[0] ^ id[0];
   endfunction
   function automatic logic [23:0] f_res_mant(input int id, input int tag);
      logic [26:0] m;
      m = f_mant(id, tag);
      return m[26:3];
   endfunction
   function automatic logic [7:0] f_res_exp(input int id, input int tag);
      logic [9:0] e;
      e = f_exp(id, tag);
      return e[7:0];
   endfunction

   task automatic drive_req(input int id, input int tag);
      logic ix;
      ix = 1'(id);
      bus.Mant_DI[ix] = f_mant(id, tag);
      bus.Exp_DI[ix]  = f_exp(id, tag);
      bus.Sign_DI[ix] = f_sign(id, tag);
      bus.RM_DI[ix]   = 3'(tag);
      bus.OP_DI[ix]   = 4'(tag + id);
      bus.Tag_DI[ix]  = 4'(tag);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.Res_Ready_SI = 1'b1;
      drive_req(0, 3);
      drive_req(1, 4);
      bus.Valid_SI = 2'b11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.Ready_SO !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", bus.Ready_SO); end
      checks++; if (bus.Res_Valid_SO !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", bus.Res_Valid_SO); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (bus.Res_Mant_DO !== 24'h0) begin failures++; $display("FAIL reset_res_mant got=%h exp=0", bus.Res_Mant_DO); end
      checks++; if (norm_mant_o !== 27'h0) begin failures++; $display("FAIL reset_norm_mant got=%h exp=0", norm_mant_o); end
      cyc(); rst_n = 1'b1; bus.Valid_SI = 2'b00;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_rel_busy got=%b exp=0", busy); end
   endtask

   task automatic test_single();
      cyc(); drive_req(1, 5); bus.Valid_SI = 2'b10; bus.Res_Ready_SI = 1'b1;
      @(negedge clk);
      checks++; if (bus.Ready_SO !== 2'b10) begin failures++; $display("FAIL single_ready got=%b exp=10", bus.Ready_SO); end
      cyc(); bus.Valid_SI = 2'b00;
      @(negedge clk);
      checks++; if (norm_mant_o !== f_mant(1, 5)) begin failures++; $display("FAIL single_norm_mant got=%h exp=%h", norm_mant_o, f_mant(1, 5)); end
      checks++; if (norm_exp_o !== f_exp(1, 5)) begin failures++; $display("FAIL single_norm_exp got=%h exp=%h", norm_exp_o, f_exp(1, 5)); end
      checks++; if ({norm_sign_o, norm_rm_o, norm_op_o} !== {f_sign(1, 5), 3'd5, 4'd6}) begin failures++; $display("FAIL single_norm_ctl got=%b exp=%b", {norm_sign_o, norm_rm_o, norm_op_o}, {f_sign(1, 5), 3'd5, 4'd6}); end
      checks++; if ({bus.Res_Valid_SO, busy} !== 2'b01) begin failures++; $display("FAIL single_k1_state got=%b exp=01", {bus.Res_Valid_SO, busy}); end
      cyc();
      @(negedge clk);
      checks++; if (bus.Res_Valid_SO !== 1'b1) begin failures++; $display("FAIL single_res_valid got=%b exp=1", bus.Res_Valid_SO); end
      checks++; if ({bus.Res_Id_DO, bus.Res_Tag_DO} !== 5'b1_0101) begin failures++; $display("FAIL single_id_tag got=%b exp=10101", {bus.Res_Id_DO, bus.Res_Tag_DO}); end
      checks++; if (bus.Res_Mant_DO !== f_res_mant(1, 5)) begin failures++; $display("FAIL single_res_mant got=%h exp=%h", bus.Res_Mant_DO, f_res_mant(1, 5)); end
      checks++; if (bus.Res_Exp_DO !== f_res_exp(1, 5)) begin failures++; $display("FAIL single_res_exp got=%h exp=%h", bus.Res_Exp_DO, f_res_exp(1, 5)); end
      // tag 5: sign 1^1=0, rounded=1, OF=1, UF=0
      checks++; if ({bus.Res_Sign_SO, bus.Res_Rounded_SO, bus.Res_OF_SO, bus.Res_UF_SO} !== 4'b0110) begin failures++; $display("FAIL single_flags got=%b exp=0110", {bus.Res_Sign_SO, bus.Res_Rounded_SO, bus.Res_OF_SO, bus.Res_UF_SO}); end
      cyc();
      @(negedge clk);
      checks++; if ({bus.Res_Valid_SO, busy} !== 2'b00) begin failures++; $display("FAIL single_drain got=%b exp=00", {bus.Res_Valid_SO, busy}); end
   endtask

   task automatic test_contention();
      logic [1:0] exp_rdy;
      logic       exp_id;
      for (int i = 0; i < 9; i++) begin
         cyc();
         drive_req(0, 10); drive_req(1, 11);
         bus.Res_Ready_SI = 1'b1;
         bus.Valid_SI = (i < 6) ? 2'b11 : 2'b00;
`ifdef FPU_NORM_ARB_FIXED_PRIO_EN
         exp_rdy = 2'b01;
         exp_id  = 1'b0;
`else
         exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_id  = ((i - 2) % 2 == 0) ? 1'b0 : 1'b1;
`endif
         @(negedge clk);
         if (i < 6) begin
            checks++; if (bus.Ready_SO !== exp_rdy) begin failures++; $display("FAIL contention_grant_%0d got=%b exp=%b", i, bus.Ready_SO, exp_rdy); end
         end
         checks++; if (bus.Res_Valid_SO !== (i >= 2 && i < 8)) begin failures++; $display("FAIL contention_valid_%0d got=%b exp=%b", i, bus.Res_Valid_SO, (i >= 2 && i < 8)); end
         if (i >= 2 && i < 8) begin
            checks++; if ({bus.Res_Id_DO, bus.Res_Tag_DO} !== {exp_id, exp_id ? 4'hB : 4'hA}) begin failures++; $display("FAIL contention_id_%0d got=%b exp=%b", i, {bus.Res_Id_DO, bus.Res_Tag_DO}, {exp_id, exp_id ? 4'hB : 4'hA}); end
         end
      end
   endtask

   task automatic test_backpressure();
      cyc(); bus.Res_Ready_SI = 1'b0; drive_req(0, 1); bus.Valid_SI = 2'b01;
      @(negedge clk);
      checks++; if (bus.Ready_SO !== 2'b01) begin failures++; $display("FAIL bp_acc1 got=%b exp=01", bus.Ready_SO); end
      cyc(); drive_req(0, 2);
      @(negedge clk);
      checks++; if (bus.Ready_SO !== 2'b01) begin failures++; $display("FAIL bp_acc2 got=%b exp=01", bus.Ready_SO); end
      for (int i = 0; i < 2; i++) begin
         cyc(); drive_req(0, 3);
         @(negedge clk);
         checks++; if (bus.Ready_SO !== 2'b00) begin failures++; $display("FAIL bp_stall_rdy_%0d got=%b exp=00", i, bus.Ready_SO); end
         checks++; if ({bus.Res_Valid_SO, busy, bus.Res_Tag_DO} !== 6'b11_0001) begin failures++; $display("FAIL bp_stall_hold_%0d got=%b exp=110001", i, {bus.Res_Valid_SO, busy, bus.Res_Tag_DO}); end
      end
      cyc(); bus.Res_Ready_SI = 1'b1;
      @(negedge clk);
      checks++; if (bus.Ready_SO !== 2'b01) begin failures++; $display("FAIL bp_release_rdy got=%b exp=01", bus.Ready_SO); end
      checks++; if ({bus.Res_Valid_SO, bus.Res_Tag_DO} !== 5'b1_0001) begin failures++; $display("FAIL bp_out1 got=%b exp=10001", {bus.Res_Valid_SO, bus.Res_Tag_DO}); end
      cyc(); bus.Valid_SI = 2'b00;
      @(negedge clk);
      checks++; if ({bus.Res_Valid_SO, bus.Res_Tag_DO} !== 5'b1_0010) begin failures++; $display("FAIL bp_out2 got=%b exp=10010", {bus.Res_Valid_SO, bus.Res_Tag_DO}); end
      cyc();
      @(negedge clk);
      checks++; if ({bus.Res_Valid_SO, bus.Res_Tag_DO} !== 5'b1_0011) begin failures++; $display("FAIL bp_out3 got=%b exp=10011", {bus.Res_Valid_SO, bus.Res_Tag_DO}); end
      cyc();
      @(negedge clk);
      checks++; if (bus.Res_Valid_SO !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", bus.Res_Valid_SO); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_rdy;
      for (int i = 0; i < 3; i++) begin
         cyc(); bus.Res_Ready_SI = 1'b0; drive_req(1, i); bus.Valid_SI = 2'b10;
         exp_rdy = (i < 2) ? 2'b10 : 2'b00;
         @(negedge clk);
         checks++; if (bus.Ready_SO !== exp_rdy) begin failures++; $display("FAIL b2b_fill_%0d got=%b exp=%b", i, bus.Ready_SO, exp_rdy); end
      end
      for (int i = 0; i < 8; i++) begin
         cyc(); bus.Res_Ready_SI = 1'b1; drive_req(1, i + 2);
         @(negedge clk);
         checks++; if (bus.Ready_SO !== 2'b10) begin failures++; $display("FAIL b2b_rdy_%0d got=%b exp=10", i, bus.Ready_SO); end
         checks++; if ({bus.Res_Valid_SO, bus.Res_Tag_DO} !== {1'b1, 4'(i)}) begin failures++; $display("FAIL b2b_res_%0d got=%b exp=%b", i, {bus.Res_Valid_SO, bus.Res_Tag_DO}, {1'b1, 4'(i)}); end
         checks++; if (bus.Res_Mant_DO !== f_res_mant(1, i)) begin failures++; $display("FAIL b2b_mant_%0d got=%h exp=%h", i, bus.Res_Mant_DO, f_res_mant(1, i)); end
      end
      for (int i = 8; i < 10; i++) begin
         cyc(); bus.Valid_SI = 2'b00;
         @(negedge clk);
         checks++; if ({bus.Res_Valid_SO, bus.Res_Tag_DO} !== {1'b1, 4'(i)}) begin failures++; $display("FAIL b2b_tail_%0d got=%b exp=%b", i, {bus.Res_Valid_SO, bus.Res_Tag_DO}, {1'b1, 4'(i)}); end
      end
      cyc();
      @(negedge clk);
      checks++; if ({bus.Res_Valid_SO, busy} !== 2'b00) begin failures++; $display("FAIL b2b_drain got=%b exp=00", {bus.Res_Valid_SO, busy}); end
   endtask

   task automatic test_reset_mid();
      cyc(); bus.Res_Ready_SI = 1'b0; drive_req(0, 12); bus.Valid_SI = 2'b01;
      cyc(); drive_req(0, 13);
      @(negedge clk);
      checks++; if (bus.Ready_SO !== 2'b01) begin failures++; $display("FAIL rmid_fill got=%b exp=01", bus.Ready_SO); end
      cyc(); rst_n = 1'b0; bus.Valid_SI = 2'b11;
      @(negedge clk);
      checks++; if ({bus.Ready_SO, bus.Res_Valid_SO, busy} !== 4'b0000) begin failures++; $display("FAIL rmid_during got=%b exp=0000", {bus.Ready_SO, bus.Res_Valid_SO, busy}); end
      cyc(); rst_n = 1'b1; bus.Valid_SI = 2'b00;
      @(negedge clk);
      checks++; if ({bus.Res_Valid_SO, busy} !== 2'b00) begin failures++; $display("FAIL rmid_after got=%b exp=00", {bus.Res_Valid_SO, busy}); end
      checks++; if ({bus.Res_Mant_DO, bus.Res_Exp_DO, bus.Res_Id_DO, bus.Res_Tag_DO} !== 37'h0) begin failures++; $display("FAIL rmid_res_zero got=%h exp=0", {bus.Res_Mant_DO, bus.Res_Exp_DO, bus.Res_Id_DO, bus.Res_Tag_DO}); end
      checks++; if ({norm_mant_o, norm_exp_o} !== 37'h0) begin failures++; $display("FAIL rmid_norm_zero got=%h exp=0", {norm_mant_o, norm_exp_o}); end
      cyc(); bus.Res_Ready_SI = 1'b1; drive_req(0, 14); drive_req(1, 15); bus.Valid_SI = 2'b11;
      @(negedge clk);
      checks++; if (bus.Ready_SO !== 2'b01) begin failures++; $display("FAIL rmid_first_grant got=%b exp=01", bus.Ready_SO); end
      cyc(); bus.Valid_SI = 2'b00;
      cyc();
      @(negedge clk);
      checks++; if ({bus.Res_Valid_SO, bus.Res_Id_DO, bus.Res_Tag_DO} !== 6'b10_1110) begin failures++; $display("FAIL rmid_result got=%b exp=101110", {bus.Res_Valid_SO, bus.Res_Id_DO, bus.Res_Tag_DO}); end
   endtask

   task automatic test_idle();
      logic [1:0] exp_rdy;
      for (int i = 0; i < 5; i++) begin
         cyc(); bus.Valid_SI = 2'b00;
         @(negedge clk);
         if (i > 0) begin
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy_%0d got=%b exp=0", i, busy); end
         end
         checks++; if ({norm_mant_o, norm_exp_o} !== {f_mant(0, 14), f_exp(0, 14)}) begin failures++; $display("FAIL idle_norm_%0d got=%h exp=%h", i, {norm_mant_o, norm_exp_o}, {f_mant(0, 14), f_exp(0, 14)}); end
      end
`ifdef FPU_NORM_ARB_FIXED_PRIO_EN
      exp_rdy = 2'b01;
`else
      exp_rdy = 2'b10;
`endif
      cyc(); drive_req(0, 6); drive_req(1, 7); bus.Valid_SI = 2'b11;
      @(negedge clk);
      checks++; if (bus.Ready_SO !== exp_rdy) begin failures++; $display("FAIL idle_ptr_hold got=%b exp=%b", bus.Ready_SO, exp_rdy); end
      cyc(); bus.Valid_SI = 2'b00;
      repeat (3) cyc();
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_final_busy got=%b exp=0", busy); end
   endtask

   initial begin
      bus.Valid_SI     = '0;
      bus.Mant_DI      = '0;
      bus.Exp_DI       = '0;
      bus.Sign_DI      = '0;
      bus.RM_DI        = '0;
      bus.OP_DI        = '0;
      bus.Tag_DI       = '0;
      bus.Res_Ready_SI = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
